issue_unit: RTL and testbench

ISSUE_UNIT -- requirements
Module: issue

---
 rtl/issue_unit.sv | 163 ++++++++++++++++
 tb/tb_issue_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_unit.sv
// In-order issue stage: decodes, renames sources, allocates a ROB entry and a
// reservation station / LSQ slot per instruction, and retires the ROB head on commit.
module issue_unit #(
  parameter int unsigned ROB_DEPTH = 8,
  parameter int unsigned ADD_RS    = 3,
  parameter int unsigned MUL_RS    = 3,
  parameter int unsigned BCH_RS    = 2,
  parameter int unsigned LSQ_DEPTH = 4
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] func,
  input  logic [3:0] rs1,
  input  logic [3:0] rs2,
  input  logic [3:0] rd,
  input  logic       commit,
  input  logic       rel_valid,
  input  logic [1:0] rel_class,
  input  logic [1:0] rel_slot,
  output logic       stall,
  output logic       issued,
  output logic [2:0] rob_idx,
  output logic [1:0] rs_class,
  output logic [1:0] rs_slot,
  output logic       src1_busy,
  output logic       src2_busy,
  output logic [2:0] src1_rob,
  output logic [2:0] src2_rob,
  output logic [2:0] rob_head,
  output logic [2:0] rob_tail,
  output logic [3:0] rob_count
);

  localparam logic [3:0] AddMask = 4'((1 << ADD_RS) - 1);
  localparam logic [3:0] MulMask = 4'((1 << MUL_RS) - 1);
  localparam logic [3:0] BchMask = 4'((1 << BCH_RS) - 1);
  localparam logic [3:0] LsqMask = 4'((1 << LSQ_DEPTH) - 1);

  logic       r_ren_busy [16];
  logic [2:0] r_ren_tag  [16];
  logic [3:0] r_rob_dest [ROB_DEPTH];
  logic       r_rob_hasd [ROB_DEPTH];
  logic [3:0] r_rs_busy  [4];
  logic [2:0] r_head, r_tail;
  logic [3:0] r_count;

  logic       r_issued, r_src1_busy, r_src2_busy;
  logic [2:0] r_rob_idx, r_src1_rob, r_src2_rob;
  logic [1:0] r_rs_class, r_rs_slot;

  logic       w_legal, w_has_dest, w_accept, w_commit, w_rob_full;
  logic [1:0] w_cls, w_slot;
  logic [3:0] w_mask [4];
  logic [3:0] w_free;
  logic       w_src1_busy, w_src2_busy;

  always_comb begin
    w_mask[0] = AddMask;
    w_mask[1] = MulMask;
    w_mask[2] = BchMask;
    w_mask[3] = LsqMask;
  end

  always_comb begin
    w_legal    = ~func[3];
    w_has_dest = w_legal && (func <= 4'd4);
    w_cls      = 2'd0;
    unique case (func[2:1])
      2'b00: w_cls = 2'd0;
      2'b01: w_cls = 2'd1;
      2'b11: w_cls = 2'd2;
      2'b10: w_cls = 2'd3;
      default: w_cls = 2'd0;
    endcase
  end

  always_comb begin
    w_free = ~r_rs_busy[w_cls] & w_mask[w_cls];
    w_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_free[i]) w_slot = 2'(i);
    end
  end

  // Decisions use only pre-edge state, so same-cycle commits/releases never unblock.
  assign w_rob_full = (r_count == 4'(ROB_DEPTH));
  assign w_accept   = in_valid && w_legal && !w_rob_full && (w_free != 4'd0);
  assign w_commit   = commit && (r_count != 4'd0);
  assign stall      = in_valid && w_legal && !w_accept;

  // A source whose producer retires this cycle is already available.
  assign w_src1_busy = r_ren_busy[rs1] && !(w_commit && (r_ren_tag[rs1] == r_head));
  assign w_src2_busy = r_ren_busy[rs2] && !(w_commit && (r_ren_tag[rs2] == r_head));

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_ren_busy[i] <= 1'b0;
        r_ren_tag[i]  <= 3'd0;
      end
      for (int i = 0; i < int'(ROB_DEPTH); i++) begin
        r_rob_dest[i] <= 4'd0;
        r_rob_hasd[i] <= 1'b0;
      end
      for (int i = 0; i < 4; i++) r_rs_busy[i] <= 4'd0;
      r_head      <= 3'd0;
      r_tail      <= 3'd0;
      r_count     <= 4'd0;
      r_issued    <= 1'b0;
      r_rob_idx   <= 3'd0;
      r_rs_class  <= 2'd0;
      r_rs_slot   <= 2'd0;
      r_src1_busy <= 1'b0;
      r_src2_busy <= 1'b0;
      r_src1_rob  <= 3'd0;
      r_src2_rob  <= 3'd0;
    end else begin
      // Commit clear first; a same-edge rename write below overrides it.
      if (w_commit) begin
        r_head <= r_head + 3'd1;
        if (r_rob_hasd[r_head] && (r_ren_tag[r_rob_dest[r_head]] == r_head)) begin
          r_ren_busy[r_rob_dest[r_head]] <= 1'b0;
        end
      end
      if (rel_valid && w_mask[rel_class][rel_slot]) begin
        r_rs_busy[rel_class][rel_slot] <= 1'b0;
      end
      r_issued <= w_accept;
      if (w_accept) begin
        r_rs_busy[w_cls][w_slot] <= 1'b1;
        r_rob_dest[r_tail]       <= rd;
        r_rob_hasd[r_tail]       <= w_has_dest;
        r_tail                   <= r_tail + 3'd1;
        if (w_has_dest) begin
          r_ren_busy[rd] <= 1'b1;
          r_ren_tag[rd]  <= r_tail;
        end
        r_rob_idx   <= r_tail;
        r_rs_class  <= w_cls;
        r_rs_slot   <= w_slot;
        r_src1_busy <= w_src1_busy;
        r_src2_busy <= w_src2_busy;
        r_src1_rob  <= r_ren_tag[rs1];
        r_src2_rob  <= r_ren_tag[rs2];
      end
      r_count <= r_count + {3'd0, w_accept} - {3'd0, w_commit};
    end
  end

  assign issued    = r_issued;
  assign rob_idx   = r_rob_idx;
  assign rs_class  = r_rs_class;
  assign rs_slot   = r_rs_slot;
  assign src1_busy = r_src1_busy;
  assign src2_busy = r_src2_busy;
  assign src1_rob  = r_src1_rob;
  assign src2_rob  = r_src2_rob;
  assign rob_head  = r_head;
  assign rob_tail  = r_tail;
  assign rob_count = r_count;

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: rename, station allocation, ROB wrap, bypass, reset.
module tb_issue_unit;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic       in_valid, commit, rel_valid;
  logic [3:0] func, rs1, rs2, rd;
  logic [1:0] rel_class, rel_slot;
  logic       stall, issued, src1_busy, src2_busy;
  logic [2:0] rob_idx, src1_rob, src2_rob, rob_head, rob_tail;
  logic [1:0] rs_class, rs_slot;
  logic [3:0] rob_count;

  int n_checks = 0;
  int n_errors = 0;

  issue_unit dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .func      (func),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .commit    (commit),
    .rel_valid (rel_valid),
    .rel_class (rel_class),
    .rel_slot  (rel_slot),
    .stall     (stall),
    .issued    (issued),
    .rob_idx   (rob_idx),
    .rs_class  (rs_class),
    .rs_slot   (rs_slot),
    .src1_busy (src1_busy),
    .src2_busy (src2_busy),
    .src1_rob  (src1_rob),
    .src2_rob  (src2_rob),
    .rob_head  (rob_head),
    .rob_tail  (rob_tail),
    .rob_count (rob_count)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs (after an edge) and let combinational outputs settle.
  task automatic drive(input logic v, input logic [3:0] f, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] d, input logic c,
                       input logic rv, input logic [1:0] rc, input logic [1:0] rsl);
    in_valid = v; func = f; rs1 = a; rs2 = b; rd = d; commit = c;
    rel_valid = rv; rel_class = rc; rel_slot = rsl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #10;
    check("rst issued", issued, 0);
    check("rst count", rob_count, 0);
    check("rst head", rob_head, 0);
    check("rst tail", rob_tail, 0);
    check("rst stall", stall, 0);
    rst_n = 1'b1;
    tick();

    // add r1,r2->r3
    drive(1, 4'h0, 1, 2, 3, 0, 0, 0, 0);
    tick();
    check("add0 issued", issued, 1);
    check("add0 rob_idx", rob_idx, 0);
    check("add0 class", rs_class, 0);
    check("add0 slot", rs_slot, 0);
    check("add0 src1_busy", src1_busy, 0);
    check("add0 src2_busy", src2_busy, 0);
    check("add0 tail", rob_tail, 1);

    // sub r3,r3->r4 sees r3 renamed to tag 0
    drive(1, 4'h1, 3, 3, 4, 0, 0, 0, 0);
    tick();
    check("sub src1_busy", src1_busy, 1);
    check("sub src2_busy", src2_busy, 1);
    check("sub src1_rob", src1_rob, 0);
    check("sub src2_rob", src2_rob, 0);
    check("sub rob_idx", rob_idx, 1);
    check("sub slot", rs_slot, 1);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("idle issued", issued, 0);
    check("idle rob_idx hold", rob_idx, 1);

    // add r5,r6->r7 takes the last add station
    drive(1, 4'h0, 5, 6, 7, 0, 0, 0, 0);
    tick();
    check("add2 slot", rs_slot, 2);
    check("add2 rob_idx", rob_idx, 2);

    // fourth add stalls; same-cycle release does not unblock it
    drive(1, 4'h0, 0, 0, 8, 0, 1, 0, 1);
    check("add3 stall", stall, 1);
    tick();
    check("add3 not issued", issued, 0);
    drive(1, 4'h0, 0, 0, 8, 0, 0, 0, 0);
    check("add3 unstall", stall, 0);
    tick();
    check("add3 issued", issued, 1);
    check("add3 slot", rs_slot, 1);
    check("add3 rob_idx", rob_idx, 3);

    // mul r1,r1->r9
    drive(1, 4'h2, 1, 1, 9, 0, 0, 0, 0);
    tick();
    check("mul class", rs_class, 1);
    check("mul slot", rs_slot, 0);
    // store r3,r4
    drive(1, 4'h5, 3, 4, 0, 0, 0, 0, 0);
    tick();
    check("st class", rs_class, 3);
    check("st rob_idx", rob_idx, 5);
    check("st src1_rob", src1_rob, 0);
    check("st src2_rob", src2_rob, 1);
    check("st src2_busy", src2_busy, 1);
    // load r0->r10
    drive(1, 4'h4, 0, 0, 10, 0, 0, 0, 0);
    tick();
    check("ld slot", rs_slot, 1);
    // beq r1,r2 imm 5
    drive(1, 4'h6, 1, 2, 5, 0, 0, 0, 0);
    tick();
    check("beq class", rs_class, 2);
    check("beq rob_idx", rob_idx, 7);
    check("full count", rob_count, 8);
    check("full tail wrap", rob_tail, 0);

    // ninth (div r7,r4->r11) stalls on full ROB even with commit this cycle
    drive(1, 4'h3, 7, 4, 11, 1, 0, 0, 0);
    check("div stall full", stall, 1);
    tick();
    check("div not issued", issued, 0);
    check("commit count", rob_count, 7);
    check("commit head", rob_head, 1);
    drive(1, 4'h3, 7, 4, 11, 0, 0, 0, 0);
    check("div unstall", stall, 0);
    tick();
    check("div issued", issued, 1);
    check("div rob_idx wrap", rob_idx, 0);
    check("div slot", rs_slot, 1);
    check("div src1_busy", src1_busy, 1);
    check("div src1_rob", src1_rob, 2);
    check("div src2_busy", src2_busy, 1);
    check("div src2_rob", src2_rob, 1);

    // commit sub (r4) and release add slot 0
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    check("c2 head", rob_head, 2);
    check("c2 count", rob_count, 7);

    // add r7,r3->r12 with commit of r7's producer: bypass
    drive(1, 4'h0, 7, 3, 12, 1, 0, 0, 0);
    tick();
    check("byp issued", issued, 1);
    check("byp src1_busy", src1_busy, 0);
    check("byp src1_rob", src1_rob, 2);
    check("byp src2_busy", src2_busy, 0);
    check("byp rob_idx", rob_idx, 1);
    check("byp count", rob_count, 7);
    check("byp head", rob_head, 3);

    // mul r1,r1->r8 while committing r8's old producer: rename wins
    drive(1, 4'h2, 1, 1, 8, 1, 0, 0, 0);
    tick();
    check("mul2 slot", rs_slot, 2);
    check("mul2 rob_idx", rob_idx, 2);
    check("mul2 count", rob_count, 7);
    // store r8,r5: r8 -> tag 2 busy, r5 never renamed by beq
    drive(1, 4'h5, 8, 5, 0, 0, 0, 0, 0);
    tick();
    check("st2 src1_busy", src1_busy, 1);
    check("st2 src1_rob", src1_rob, 2);
    check("st2 src2_busy", src2_busy, 0);
    check("st2 slot", rs_slot, 2);
    check("st2 count", rob_count, 8);

    // illegal func with full ROB: no stall, no issue
    drive(1, 4'hA, 0, 0, 0, 0, 0, 0, 0);
    check("illegal stall", stall, 0);
    tick();
    check("illegal issued", issued, 0);
    check("illegal count", rob_count, 8);

    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    tick();
    tick();
    check("pre-rst count", rob_count, 5);
    check("pre-rst head", rob_head, 7);
    check("pre-rst tail", rob_tail, 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // asynchronous reset away from the clock edge
    rst_n = 1'b0;
    #1;
    check("arst count", rob_count, 0);
    check("arst head", rob_head, 0);
    check("arst tail", rob_tail, 0);
    check("arst rob_idx", rob_idx, 0);
    check("arst src1_rob", src1_rob, 0);
    check("arst rs_slot", rs_slot, 0);
    rst_n = 1'b1;
    tick();
    drive(1, 4'h0, 8, 3, 3, 0, 0, 0, 0);
    tick();
    check("post issued", issued, 1);
    check("post rob_idx", rob_idx, 0);
    check("post slot", rs_slot, 0);
    check("post src1_busy", src1_busy, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
